// File: rtl/line_interp_p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interp_pkg
//  Description : Shared types and width helpers for the interpolator family.
//  Revision    : 1.0  initial release
// ============================================================================
package interp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        STEP_NONE = 3'd0,
        STEP_XP   = 3'd1,
        STEP_XN   = 3'd2,
        STEP_YP   = 3'd3,
        STEP_YN   = 3'd4
    } step_t;

    // Error needs two extra bits over the coordinate width, step count one.
    localparam int ERR_PAD = 2;
    localparam int CNT_PAD = 1;

    function automatic int err_w(input int w);
        return w + ERR_PAD;
    endfunction

    function automatic int cnt_w(input int w);
        return w + CNT_PAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_interp_p_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_interp_p_if
//  Description : Command/status bundle between motion decoder and interpolator.
//  Revision    : 1.0  initial release
// ============================================================================
interface line_interp_p_if #(
    parameter int W     = 16,
    parameter int DIV_W = 16
);
    logic                 start;
    logic                 abort;
    logic signed [W-1:0]  xe;
    logic signed [W-1:0]  ye;
    logic [DIV_W-1:0]     step_period;
    logic                 busy;
    logic                 done;
    logic                 x_acc;
    logic                 x_dec;
    logic                 y_acc;
    logic                 y_dec;
    logic [W:0]           steps_left;

    modport master (
        output start, abort, xe, ye, step_period,
        input  busy, done, x_acc, x_dec, y_acc, y_dec, steps_left
    );

    modport slave (
        input  start, abort, xe, ye, step_period,
        output busy, done, x_acc, x_dec, y_acc, y_dec, steps_left
    );
endinterface
`default_nettype wire

// File: rtl/line_interp_p_step_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : step_rate_gen
//  Description : Loadable down-counter; o_tick is high while the count is zero.
//  Revision    : 1.0  initial release
// ============================================================================
module step_rate_gen #(
    parameter int DIV_W = 16
) (
    input  wire logic             sys_clk,
    input  wire logic             sys_rst,
    input  wire logic             i_load,
    input  wire logic             i_count_en,
    input  wire logic [DIV_W-1:0] i_load_val,
    output logic                  o_tick
);
    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/line_interp_p.sv
`default_nettype none
// ============================================================================
//  Module      : line_interp_p
//  Description : Point-by-point comparison line interpolator, any quadrant.
//  Revision    : 1.0  initial release
// ============================================================================
module line_interp_p
    import interp_pkg::*;
#(
    parameter int W     = 16,
    parameter int DIV_W = 16
) (
    input  wire logic      sys_clk,
    input  wire logic      sys_rst,
    line_interp_p_if.slave bus
);
    localparam int ERR_W = err_w(W);
    localparam int CNT_W = cnt_w(W);

    state_t                   r_state;
    logic [W-1:0]             r_ax;
    logic [W-1:0]             r_ay;
    logic                     r_x_pos;
    logic                     r_y_pos;
    logic signed [ERR_W-1:0]  r_err;
    logic [CNT_W-1:0]         r_steps_left;
    logic [DIV_W-1:0]         r_period;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_x_acc;
    logic                     r_x_dec;
    logic                     r_y_acc;
    logic                     r_y_dec;

    logic [W-1:0]             w_ax;
    logic [W-1:0]             w_ay;
    logic                     w_tick;
    logic                     w_accept;
    logic                     w_step_go;
    logic                     w_take_x;
    step_t                    w_step;
    logic [DIV_W-1:0]         w_load_val;

    // Magnitude as unsigned W bits, so the most negative value maps cleanly.
    assign w_ax = bus.xe[W-1] ? (~bus.xe + W'(1)) : bus.xe;
    assign w_ay = bus.ye[W-1] ? (~bus.ye + W'(1)) : bus.ye;

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_step_go  = (r_state == RUN) && !bus.abort && w_tick && (r_steps_left != '0);
    assign w_load_val = (r_state == IDLE) ? bus.step_period : r_period;

    always_comb begin
        w_take_x = 1'b0;
        if (r_ay == '0) begin
            w_take_x = 1'b1;
        end else if (r_ax != '0) begin
            w_take_x = !r_err[ERR_W-1];
        end
        if (w_take_x) begin
            w_step = r_x_pos ? STEP_XP : STEP_XN;
        end else begin
            w_step = r_y_pos ? STEP_YP : STEP_YN;
        end
    end

    step_rate_gen #(
        .DIV_W (DIV_W)
    ) u_rate (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .i_load     (w_accept || w_step_go),
        .i_count_en (r_state == RUN),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_ax         <= '0;
            r_ay         <= '0;
            r_x_pos      <= 1'b0;
            r_y_pos      <= 1'b0;
            r_err        <= '0;
            r_steps_left <= '0;
            r_period     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_x_acc      <= 1'b0;
            r_x_dec      <= 1'b0;
            r_y_acc      <= 1'b0;
            r_y_dec      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_x_acc <= 1'b0;
            r_x_dec <= 1'b0;
            r_y_acc <= 1'b0;
            r_y_dec <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state      <= RUN;
                        r_busy       <= 1'b1;
                        r_ax         <= w_ax;
                        r_ay         <= w_ay;
                        r_x_pos      <= !bus.xe[W-1] && (bus.xe != '0);
                        r_y_pos      <= !bus.ye[W-1] && (bus.ye != '0);
                        r_err        <= '0;
                        r_steps_left <= {1'b0, w_ax} + {1'b0, w_ay};
                        r_period     <= bus.step_period;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_tick && (r_steps_left == '0)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_step_go) begin
                        r_steps_left <= r_steps_left - CNT_W'(1);
                        r_x_acc      <= (w_step == STEP_XP);
                        r_x_dec      <= (w_step == STEP_XN);
                        r_y_acc      <= (w_step == STEP_YP);
                        r_y_dec      <= (w_step == STEP_YN);
                        // A zero magnitude on the other axis makes these no-ops.
                        if (w_take_x) begin
                            r_err <= r_err - $signed({2'b00, r_ay});
                        end else begin
                            r_err <= r_err + $signed({2'b00, r_ax});
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.x_acc      = r_x_acc;
    assign bus.x_dec      = r_x_dec;
    assign bus.y_acc      = r_y_acc;
    assign bus.y_dec      = r_y_dec;
    assign bus.steps_left = r_steps_left;
endmodule
`default_nettype wire

// File: tb/tb_line_interp_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_interp_p
//  Description : Scoreboard bench for line_interp_p with a reference line model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_interp_p;
    localparam int W     = 16;
    localparam int DIV_W = 16;

    // Event kinds: 0 X+, 1 X-, 2 Y+, 3 Y-, 4 done, 9 several at once.
    typedef struct {
        int kind;
        int offs;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   move_base   = 0;
    int   net_x       = 0;
    int   net_y       = 0;
    int   pulse_cnt   = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    line_interp_p_if #(.W(W), .DIV_W(DIV_W)) bus ();

    line_interp_p #(.W(W), .DIV_W(DIV_W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Walk the line: on or above it move along X, below it move along Y.
    task automatic push_move(input int xe, input int ye, input int p,
                             input int max_pulses, input bit with_done);
        int   ax, ay, err, n;
        exp_t e;
        ax  = iabs(xe);
        ay  = iabs(ye);
        n   = ax + ay;
        err = 0;
        for (int i = 0; i < n; i++) begin
            bit take_x;
            take_x = (ay == 0) || ((ax != 0) && (err >= 0));
            if (i < max_pulses) begin
                e.kind = take_x ? ((xe > 0) ? 0 : 1) : ((ye > 0) ? 2 : 3);
                e.offs = 1 + p + i * (p + 1);
                sb.push_back(e);
            end
            if (take_x) err -= ay;
            else        err += ax;
        end
        if (with_done) begin
            e.kind = 4;
            e.offs = n * (p + 1) + p + 1;
            sb.push_back(e);
        end
    endtask

    always @(negedge sys_clk) begin
        int   n, kind;
        exp_t e;
        n = int'(bus.x_acc) + int'(bus.x_dec) + int'(bus.y_acc) + int'(bus.y_dec) + int'(bus.done);
        if (!sys_rst && (n != 0)) begin
            if (n > 1)           kind = 9;
            else if (bus.x_acc)  kind = 0;
            else if (bus.x_dec)  kind = 1;
            else if (bus.y_acc)  kind = 2;
            else if (bus.y_dec)  kind = 3;
            else                 kind = 4;
            case (kind)
                0: begin net_x++; pulse_cnt++; end
                1: begin net_x--; pulse_cnt++; end
                2: begin net_y++; pulse_cnt++; end
                3: begin net_y--; pulse_cnt++; end
                default: ;
            endcase
            if (sb.size() == 0) begin
                check("unexpected_output", kind, -1);
            end else begin
                e = sb.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc - move_base, e.offs);
                if (kind == 4) begin
                    check("done_steps_left", bus.steps_left, 0);
                    check("done_busy", bus.busy, 0);
                end
            end
        end
    end

    task automatic launch(input int xe, input int ye, input int p, input bit with_abort);
        net_x = 0;
        net_y = 0;
        pulse_cnt = 0;
        bus.xe          = W'(xe);
        bus.ye          = W'(ye);
        bus.step_period = DIV_W'(p);
        bus.start       = 1'b1;
        bus.abort       = with_abort;
        @(posedge sys_clk);
        @(negedge sys_clk); #1;
        move_base = cyc;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("steps_left_loaded", bus.steps_left, iabs(xe) + iabs(ye));
    endtask

    task automatic run_move(input int xe, input int ye, input int p,
                            input bit with_abort, input int busy_start_at);
        int n, budget, t;
        n = iabs(xe) + iabs(ye);
        @(negedge sys_clk); #1;
        push_move(xe, ye, p, n, 1'b1);
        launch(xe, ye, p, with_abort);
        budget = n * (p + 1) + p + 20;
        t = 0;
        while ((sb.size() != 0) && (budget > 0)) begin
            bus.start = (t == busy_start_at);
            if (t == busy_start_at) begin
                bus.xe = W'(xe + 3);
                bus.ye = W'(-ye - 5);
            end
            @(negedge sys_clk); #1;
            budget--;
            t++;
        end
        bus.start = 1'b0;
        check("move_timeout", sb.size(), 0);
        sb.delete();
        check("net_x", net_x, xe);
        check("net_y", net_y, ye);
        check("idle_busy", bus.busy, 0);
        check("final_steps_left", bus.steps_left, 0);
    endtask

    task automatic abort_move(input int xe, input int ye, input int p, input int after);
        int budget;
        @(negedge sys_clk); #1;
        push_move(xe, ye, p, after, 1'b0);
        launch(xe, ye, p, 1'b0);
        budget = after * (p + 1) + p + 20;
        while ((pulse_cnt < after) && (budget > 0)) begin
            @(negedge sys_clk); #1;
            budget--;
        end
        check("abort_reach_timeout", pulse_cnt, after);
        bus.abort = 1'b1;
        @(negedge sys_clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_steps_left", bus.steps_left, iabs(xe) + iabs(ye) - after);
        repeat (3 * (p + 1) + 5) @(negedge sys_clk);
        #1;
        check("abort_pulses", pulse_cnt, after);
        check("abort_pending", sb.size(), 0);
        check("abort_steps_hold", bus.steps_left, iabs(xe) + iabs(ye) - after);
        sb.delete();
    endtask

    task automatic reset_mid_move(input int xe, input int ye, input int p, input int after);
        int budget;
        @(negedge sys_clk); #1;
        push_move(xe, ye, p, iabs(xe) + iabs(ye), 1'b1);
        launch(xe, ye, p, 1'b0);
        budget = after * (p + 1) + p + 20;
        while ((pulse_cnt < after) && (budget > 0)) begin
            @(negedge sys_clk); #1;
            budget--;
        end
        check("reset_reach_timeout", pulse_cnt, after);
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pulses", int'(bus.x_acc) + int'(bus.x_dec) + int'(bus.y_acc) + int'(bus.y_dec), 0);
        check("rst_steps_left", bus.steps_left, 0);
        sb.delete();
        @(negedge sys_clk); #1;
        sys_rst = 1'b0;
        repeat (2 * (p + 1) + 5) @(negedge sys_clk);
        #1;
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_pending", sb.size(), 0);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.xe          = '0;
        bus.ye          = '0;
        bus.step_period = '0;
        sys_rst         = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_steps_left", bus.steps_left, 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Abort while idle does nothing.
        bus.abort = 1'b1;
        @(negedge sys_clk); #1;
        bus.abort = 1'b0;
        check("idle_abort_busy", bus.busy, 0);

        run_move(3, 2, 0, 1'b0, -1);
        run_move(0, -3, 2, 1'b0, -1);
        run_move(-4, 0, 0, 1'b0, -1);
        run_move(0, 0, 0, 1'b0, -1);
        run_move(0, 0, 3, 1'b0, -1);
        run_move(7, -5, 1, 1'b0, 3);
        run_move(-2, 6, 1, 1'b1, -1);
        abort_move(5, 5, 1, 3);
        run_move(-6, -3, 0, 1'b0, -1);
        reset_mid_move(10, -7, 2, 4);
        run_move(1, 1, 0, 1'b0, -1);

        for (int i = 0; i < 12; i++) begin
            int rx, ry, rp;
            rx = int'($urandom_range(40)) - 20;
            ry = int'($urandom_range(40)) - 20;
            rp = int'($urandom_range(3));
            run_move(rx, ry, rp, ($urandom_range(3) == 0), -1);
        end

        run_move(-32768, 32767, 0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
